beat_address_sequencer: RTL
===========================

Name: beat_address_sequencer

Overview:
Parametrised record/playback address generator for the beat memory. In RECORD it issues one write address per key change, up to DEPTH entries, and keeps the recorded length. In PLAY it steps a read address through the recorded length at a rate set by a built-in tick divider. At the end of the recording it either loops back to 0 or stops, depending on LOOP. It sits between the keyboard decoder (key codes) and the beat RAM address/write-enable pins.

Parameters:
ADDR_W, 8, width of the RAM address.
DEPTH, 256, maximum number of recorded entries; must satisfy 1 <= DEPTH <= 2^ADDR_W.
KEY_W, 7, width of the key code input.
TICK_DIV, 50000000, clk cycles per playback step; must be >= 2.
LOOP, 1, 1 = wrap to address 0 at the end of playback; 0 = stop and assert done.

Ports:
clk  in  1  system clock; all logic is rising-edge.
reset  in  1  synchronous, active-high reset.
record_en  in  1  level; high selects RECORD. Has priority over play_en.
play_en  in  1  level; high selects PLAY when record_en is low.
key_code  in  KEY_W  current key code from the decoder.
addr  out  ADDR_W  RAM address; registered.
wr_en  out  1  one-cycle write strobe, valid together with addr.
rd_tick  out  1  one-cycle strobe marking a new playback address on addr.
length  out  ADDR_W+1  number of entries recorded; holds 0..DEPTH.
full  out  1  high when length == DEPTH.
empty  out  1  high when length == 0.
done  out  1  high in DONE state (only possible when LOOP=0).
state  out  2  IDLE=0, RECORD=1, PLAY=2, DONE=3.

Behaviour:
- Reset: state=IDLE, addr=0, wr_en=0, rd_tick=0, length=0, done=0, tick counter=0, prev_key=0. full and empty are combinational from length, so after reset full=0 and empty=1. Reset takes effect mid-operation with no other effect and clears the recording (length=0).
- All outputs except full and empty are registered. wr_en and rd_tick are never high in the same cycle.
- IDLE:
  - record_en=1 -> RECORD. On entry: length<=0, wr_ptr<=0, addr<=0, prev_key<=key_code. No write is issued on entry.
  - else play_en=1 and length>0 -> PLAY. On entry: addr<=0, rd_tick<=1, tick counter<=TICK_DIV-1.
  - else play_en=1 and length==0 -> stay in IDLE; no strobes.
- RECORD:
  - Each cycle with key_code != prev_key: prev_key<=key_code.
  - If also length<DEPTH: addr<=wr_ptr, wr_en<=1, wr_ptr<=wr_ptr+1, length<=wr_ptr+1. Write latency is 1 cycle after the key change is sampled.
  - If length==DEPTH: the change is absorbed (prev_key updates), there is no write, and the address does not wrap.
  - record_en=0 -> IDLE with addr<=0. length is retained.
- PLAY:
  - The tick counter decrements every cycle.
  - When the counter is 0 it reloads to TICK_DIV-1. Then:
    - if addr != length-1: addr<=addr+1 and rd_tick<=1.
    - else if LOOP=1: addr<=0 and rd_tick<=1.
    - else (LOOP=0): go to DONE with done<=1; addr holds at length-1.
  - rd_tick therefore pulses once every TICK_DIV cycles.
  - record_en=1 -> RECORD (entry actions as from IDLE).
  - play_en=0 -> IDLE with addr<=0.
- DONE:
  - addr holds; no strobes.
  - play_en=0 -> IDLE with done<=0 and addr<=0.
  - record_en=1 -> RECORD with done<=0.
- Width rules: length is compared at ADDR_W+1 bits, so DEPTH = 2^ADDR_W works without overflow. The tick counter width is clog2(TICK_DIV).

Test Plan:
1. ADDR_W=2, DEPTH=4, TICK_DIV=4, LOOP=1. Record codes A,B,C (each held 3 cycles after entry with key_code=0) -> wr_en pulses with addr=0,1,2, each 1 cycle after its change; length=3; empty=0; full=0.
2. Same config, then play_en=1 -> rd_tick with addr=0 on the entry cycle, then addr=1,2,0,1… spaced exactly 4 cycles apart.
3. LOOP=0, length=3, play -> addr 0,1,2; 4 cycles after the addr=2 tick, state=DONE and done=1; no further rd_tick; dropping play_en -> IDLE, addr=0, done=0.
4. Record 6 distinct changes with DEPTH=4 -> exactly 4 wr_en pulses (addr 0..3); full=1; length=4; addr never wraps to 0.
5. Straight after reset, play_en=1 -> stays in IDLE; empty=1; no rd_tick. Then record_en and play_en raised together -> RECORD.
6. Assert reset mid-PLAY at addr=2 -> next cycle state=IDLE, addr=0, length=0, rd_tick=0; a subsequent play_en produces no playback.

Source files
------------

// File: rtl/beat_address_sequencer_if.sv
// rtl/beat_address_sequencer_if.sv - control inputs and beat RAM address bus of the sequencer
interface beat_address_sequencer_if #(
  parameter int ADDR_W = 8,
  parameter int KEY_W  = 7
);
  logic              record_en;
  logic              play_en;
  logic [KEY_W-1:0]  key_code;
  logic [ADDR_W-1:0] addr;
  logic              wr_en;
  logic              rd_tick;
  logic [ADDR_W:0]   length;
  logic              full;
  logic              empty;
  logic              done;
  logic [1:0]        state;

  modport master (
    output record_en, play_en, key_code,
    input  addr, wr_en, rd_tick, length, full, empty, done, state
  );

  modport slave (
    input  record_en, play_en, key_code,
    output addr, wr_en, rd_tick, length, full, empty, done, state
  );
endinterface

// File: rtl/beat_address_sequencer.sv
// rtl/beat_address_sequencer.sv - record/playback address generator for the beat RAM
module beat_address_sequencer #(
  parameter int ADDR_W   = 8,
  parameter int DEPTH    = 256,
  parameter int KEY_W    = 7,
  parameter int TICK_DIV = 50000000,
  parameter int LOOP     = 1
) (
  input logic                   clk,
  input logic                   reset,
  beat_address_sequencer_if.slave bus
);
  localparam int LEN_W = ADDR_W + 1;
  localparam int CNT_W = $clog2(TICK_DIV);
  localparam logic [LEN_W-1:0] DEPTH_L    = LEN_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RECORD = 2'd1,
    S_PLAY   = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [ADDR_W-1:0]  r_addr, w_addr_nxt;
  logic               r_wr_en, w_wr_en_nxt;
  logic               r_rd_tick, w_rd_tick_nxt;
  logic [LEN_W-1:0]   r_length, w_length_nxt;
  logic [LEN_W-1:0]   r_wr_ptr, w_wr_ptr_nxt;
  logic               r_done, w_done_nxt;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic [KEY_W-1:0]   r_prev_key, w_prev_key_nxt;
  logic               w_key_changed;
  logic               w_at_last;

  assign w_key_changed = (bus.key_code != r_prev_key);
  // Length is compared at ADDR_W+1 bits so DEPTH = 2^ADDR_W needs no special case.
  assign w_at_last     = ({1'b0, r_addr} == (r_length - LEN_W'(1)));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_addr     <= '0;
      r_wr_en    <= 1'b0;
      r_rd_tick  <= 1'b0;
      r_length   <= '0;
      r_wr_ptr   <= '0;
      r_done     <= 1'b0;
      r_cnt      <= '0;
      r_prev_key <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_addr     <= w_addr_nxt;
      r_wr_en    <= w_wr_en_nxt;
      r_rd_tick  <= w_rd_tick_nxt;
      r_length   <= w_length_nxt;
      r_wr_ptr   <= w_wr_ptr_nxt;
      r_done     <= w_done_nxt;
      r_cnt      <= w_cnt_nxt;
      r_prev_key <= w_prev_key_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_addr_nxt     = r_addr;
    w_wr_en_nxt    = 1'b0;
    w_rd_tick_nxt  = 1'b0;
    w_length_nxt   = r_length;
    w_wr_ptr_nxt   = r_wr_ptr;
    w_done_nxt     = r_done;
    w_cnt_nxt      = r_cnt;
    w_prev_key_nxt = r_prev_key;

    // Entering RECORD discards the previous take; the key seen on entry is not a change.
    if (bus.record_en && (r_state != S_RECORD)) begin
      w_state_nxt    = S_RECORD;
      w_length_nxt   = '0;
      w_wr_ptr_nxt   = '0;
      w_addr_nxt     = '0;
      w_prev_key_nxt = bus.key_code;
      w_done_nxt     = 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.play_en && (r_length != '0)) begin
            w_state_nxt   = S_PLAY;
            w_addr_nxt    = '0;
            w_rd_tick_nxt = 1'b1;
            w_cnt_nxt     = CNT_RELOAD;
          end
        end
        S_RECORD: begin
          if (!bus.record_en) begin
            w_state_nxt = S_IDLE;
            w_addr_nxt  = '0;
          end else if (w_key_changed) begin
            w_prev_key_nxt = bus.key_code;
            if (r_length < DEPTH_L) begin
              w_addr_nxt   = r_wr_ptr[ADDR_W-1:0];
              w_wr_en_nxt  = 1'b1;
              w_wr_ptr_nxt = r_wr_ptr + LEN_W'(1);
              w_length_nxt = r_wr_ptr + LEN_W'(1);
            end
          end
        end
        S_PLAY: begin
          if (!bus.play_en) begin
            w_state_nxt = S_IDLE;
            w_addr_nxt  = '0;
          end else if (r_cnt == '0) begin
            w_cnt_nxt = CNT_RELOAD;
            if (!w_at_last) begin
              w_addr_nxt    = r_addr + ADDR_W'(1);
              w_rd_tick_nxt = 1'b1;
            end else if (LOOP != 0) begin
              w_addr_nxt    = '0;
              w_rd_tick_nxt = 1'b1;
            end else begin
              w_state_nxt = S_DONE;
              w_done_nxt  = 1'b1;
            end
          end else begin
            w_cnt_nxt = r_cnt - CNT_W'(1);
          end
        end
        S_DONE: begin
          if (!bus.play_en) begin
            w_state_nxt = S_IDLE;
            w_done_nxt  = 1'b0;
            w_addr_nxt  = '0;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  assign bus.addr    = r_addr;
  assign bus.wr_en   = r_wr_en;
  assign bus.rd_tick = r_rd_tick;
  assign bus.length  = r_length;
  assign bus.full    = (r_length == DEPTH_L);
  assign bus.empty   = (r_length == '0);
  assign bus.done    = r_done;
  assign bus.state   = r_state;
endmodule
